// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Two-master arbiter for the single slave bus. Master 0 is
//                instruction fetch and master 1 is the load/store stage.
//                One transaction is in flight at a time. The arbiter returns
//                read data with a one-cycle ack, or with ack+err on timeout,
//                and raises a stall request toward the pipeline for each
//                master that is still waiting.
//                Optional macro ARB_RR_EN: round-robin arbitration when both
//                masters request. Without it, m1 has fixed priority.
//  Revision    : 1.0  initial release
// ============================================================================
module bus_arbiter #(
   parameter int TMO_CYCLES = 16   // legal range 1..255
) (
   input  logic        clk,
   input  logic        rst,
   // master 0 (instruction fetch)
   input  logic        m0_req_i,
   input  logic        m0_we_i,
   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m0_wdata_i,
   input  logic [3:0]  m0_sel_i,
   output logic [31:0] m0_rdata_o,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   // master 1 (load/store)
   input  logic        m1_req_i,
   input  logic        m1_we_i,
   input  logic [31:0] m1_addr_i,
   input  logic [31:0] m1_wdata_i,
   input  logic [3:0]  m1_sel_i,
   output logic [31:0] m1_rdata_o,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   // slave bus
   output logic        s_req_o,
   output logic        s_we_o,
   output logic [31:0] s_addr_o,
   output logic [31:0] s_wdata_o,
   output logic [3:0]  s_sel_o,
   input  logic [31:0] s_rdata_i,
   input  logic        s_ack_i,
   // pipeline stall requests
   output logic        stallreq_if_o,
   output logic        stallreq_mem_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // Counter value on the last BUSY cycle before the transfer is aborted.
   localparam logic [7:0] C_TMO_LAST = 8'(TMO_CYCLES - 1);

   state_t      r_state;
   logic        r_owner;
   logic        r_last_owner;
   logic [7:0]  r_cnt;
   logic        r_s_req;
   logic        r_s_we;
   logic [31:0] r_s_addr;
   logic [31:0] r_s_wdata;
   logic [3:0]  r_s_sel;
   logic [31:0] r_m0_rdata;
   logic [31:0] r_m1_rdata;
   logic        r_m0_ack;
   logic        r_m1_ack;
   logic        r_m0_err;
   logic        r_m1_err;

   logic        w_any_req;
   logic        w_grant;
   logic [31:0] w_cap_data;

   assign w_any_req  = m0_req_i | m1_req_i;
   // Writes return zero data to the master.
   assign w_cap_data = r_s_we ? 32'd0 : s_rdata_i;

`ifdef ARB_RR_EN
   // Round-robin: on contention, grant the master that did not own the bus last.
   always_comb begin
      w_grant = m1_req_i;
      if (m0_req_i && m1_req_i) begin
         w_grant = ~r_last_owner;
      end
   end
`else
   // Fixed priority: the data side (m1) wins whenever it requests.
   always_comb begin
      w_grant = m1_req_i;
   end

   // Last owner is still tracked so both builds share one state layout.
   logic w_unused_last_owner;
   assign w_unused_last_owner = r_last_owner;
`endif

   // Transaction sequencer: IDLE grants, BUSY waits for ack or timeout, RESP returns the pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_owner      <= 1'b0;
         r_last_owner <= 1'b0;
         r_cnt        <= 8'd0;
         r_s_req      <= 1'b0;
         r_s_we       <= 1'b0;
         r_s_addr     <= 32'd0;
         r_s_wdata    <= 32'd0;
         r_s_sel      <= 4'd0;
         r_m0_rdata   <= 32'd0;
         r_m1_rdata   <= 32'd0;
         r_m0_ack     <= 1'b0;
         r_m1_ack     <= 1'b0;
         r_m0_err     <= 1'b0;
         r_m1_err     <= 1'b0;
      end else begin
         r_m0_ack <= 1'b0;
         r_m1_ack <= 1'b0;
         r_m0_err <= 1'b0;
         r_m1_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_owner   <= w_grant;
                  r_s_we    <= w_grant ? m1_we_i    : m0_we_i;
                  r_s_addr  <= w_grant ? m1_addr_i  : m0_addr_i;
                  r_s_wdata <= w_grant ? m1_wdata_i : m0_wdata_i;
                  r_s_sel   <= w_grant ? m1_sel_i   : m0_sel_i;
                  r_s_req   <= 1'b1;
                  r_cnt     <= 8'd0;
                  r_state   <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (s_ack_i) begin
                  // Ack has priority over a timeout landing on the same cycle.
                  if (r_owner) begin
                     r_m1_rdata <= w_cap_data;
                     r_m1_ack   <= 1'b1;
                  end else begin
                     r_m0_rdata <= w_cap_data;
                     r_m0_ack   <= 1'b1;
                  end
                  r_s_req <= 1'b0;
                  r_state <= S_RESP;
               end else if (r_cnt == C_TMO_LAST) begin
                  if (r_owner) begin
                     r_m1_rdata <= 32'd0;
                     r_m1_ack   <= 1'b1;
                     r_m1_err   <= 1'b1;
                  end else begin
                     r_m0_rdata <= 32'd0;
                     r_m0_ack   <= 1'b1;
                     r_m0_err   <= 1'b1;
                  end
                  r_s_req <= 1'b0;
                  r_state <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_RESP: begin
               // Requests are ignored here so a still-high req is not re-granted early.
               r_last_owner <= r_owner;
               r_state      <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign s_req_o        = r_s_req;
   assign s_we_o         = r_s_we;
   assign s_addr_o       = r_s_addr;
   assign s_wdata_o      = r_s_wdata;
   assign s_sel_o        = r_s_sel;
   assign m0_rdata_o     = r_m0_rdata;
   assign m1_rdata_o     = r_m1_rdata;
   assign m0_ack_o       = r_m0_ack;
   assign m1_ack_o       = r_m1_ack;
   assign m0_err_o       = r_m0_err;
   assign m1_err_o       = r_m1_err;
   assign stallreq_if_o  = m0_req_i & ~r_m0_ack;
   assign stallreq_mem_o = m1_req_i & ~r_m1_ack;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter
//  Description : Self-checking bench for bus_arbiter. A vector table drives
//                single-master transfers; hand sequences cover contention,
//                held requests and reset during BUSY. Expected completions
//                are queued and matched by a monitor on every ack pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_arbiter;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
   logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
   logic [3:0]  m0_sel_i, m1_sel_i;
   logic [31:0] m0_rdata_o, m1_rdata_o;
   logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
   logic        s_req_o, s_we_o;
   logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
   logic [3:0]  s_sel_o;
   logic        s_ack_i;
   logic        stallreq_if_o, stallreq_mem_o;

   bus_arbiter #(.TMO_CYCLES(TMO)) u_dut (
      .clk(clk), .rst(rst),
      .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
      .m0_wdata_i(m0_wdata_i), .m0_sel_i(m0_sel_i), .m0_rdata_o(m0_rdata_o),
      .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
      .m1_wdata_i(m1_wdata_i), .m1_sel_i(m1_sel_i), .m1_rdata_o(m1_rdata_o),
      .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
      .s_wdata_o(s_wdata_o), .s_sel_o(s_sel_o), .s_rdata_i(s_rdata_i),
      .s_ack_i(s_ack_i),
      .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          m;
      logic [31:0] rd;
      logic        err;
   } exp_t;

   typedef struct {
      int          m;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  sel;
      int          k;       // slave ack sampled at edge E0+k; 0 = never ack
      logic [31:0] rd;      // data the slave returns
      logic [31:0] exp_rd;  // data the master must see
      logic        exp_err;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[9];
   int   n_vec  = 0;
   int   n_miss = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic logic ack_of(input int m);
      return (m == 1) ? m1_ack_o : m0_ack_o;
   endfunction

   function automatic logic stall_of(input int m);
      return (m == 1) ? stallreq_mem_o : stallreq_if_o;
   endfunction

   task automatic drive(input int m, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] sel);
      if (m == 1) begin
         m1_req_i = 1'b1; m1_we_i = we; m1_addr_i = addr; m1_wdata_i = wdata; m1_sel_i = sel;
      end else begin
         m0_req_i = 1'b1; m0_we_i = we; m0_addr_i = addr; m0_wdata_i = wdata; m0_sel_i = sel;
      end
   endtask

   task automatic drop(input int m);
      if (m == 1) m1_req_i = 1'b0;
      else        m0_req_i = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every ack pulse must match the oldest queued expectation.
   always @(negedge clk) begin : mon
      exp_t e;
      if (m0_ack_o === 1'b1 || m1_ack_o === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_ack", {30'd0, m1_ack_o, m0_ack_o}, 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("sb_ack_owner", {30'd0, m1_ack_o, m0_ack_o}, (e.m == 1) ? 32'd2 : 32'd1);
            chk("sb_rdata", (e.m == 1) ? m1_rdata_o : m0_rdata_o, e.rd);
            chk("sb_err", {30'd0, m1_err_o, m0_err_o},
                e.err ? ((e.m == 1) ? 32'd2 : 32'd1) : 32'd0);
         end
      end else if (m0_err_o === 1'b1 || m1_err_o === 1'b1) begin
         chk("err_without_ack", {30'd0, m1_err_o, m0_err_o}, 32'd0);
      end
   end

   // One transfer from IDLE to IDLE for a single requesting master.
   task automatic run_vec(input vec_t v, input int idx);
      int cnt;
      drive(v.m, v.we, v.addr, v.wdata, v.sel);
      sb_q.push_back('{v.m, v.exp_rd, v.exp_err});
      tick();  // E0: grant
      chk($sformatf("v%0d_sreq", idx), {31'd0, s_req_o}, 32'd1);
      chk($sformatf("v%0d_saddr", idx), s_addr_o, v.addr);
      chk($sformatf("v%0d_swe", idx), {31'd0, s_we_o}, {31'd0, v.we});
      chk($sformatf("v%0d_sel", idx), {28'd0, s_sel_o}, {28'd0, v.sel});
      if (v.we) chk($sformatf("v%0d_swdata", idx), s_wdata_o, v.wdata);
      chk($sformatf("v%0d_stall_busy", idx), {31'd0, stall_of(v.m)}, 32'd1);
      if (v.k > 0) begin
         repeat (v.k - 1) tick();
         chk($sformatf("v%0d_sreq_held", idx), {31'd0, s_req_o}, 32'd1);
         s_ack_i = 1'b1; s_rdata_i = v.rd;
         tick();
         s_ack_i = 1'b0; s_rdata_i = $urandom();
      end else begin
         cnt = 0;
         while (cnt < 40) begin
            tick();
            cnt++;
            if (s_req_o !== 1'b1) break;
         end
         chk($sformatf("v%0d_tmo_cycles", idx), cnt, TMO);
         chk($sformatf("v%0d_err_pulse", idx), {31'd0, (v.m == 1) ? m1_err_o : m0_err_o}, 32'd1);
      end
      chk($sformatf("v%0d_ack", idx), {31'd0, ack_of(v.m)}, 32'd1);
      chk($sformatf("v%0d_sreq_resp", idx), {31'd0, s_req_o}, 32'd0);
      chk($sformatf("v%0d_stall_ack", idx), {31'd0, stall_of(v.m)}, 32'd0);
      drop(v.m);
      tick();
      chk($sformatf("v%0d_ack_clear", idx), {31'd0, ack_of(v.m)}, 32'd0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : main
      int first_m, second_m;
      // m, we, addr, wdata, sel, k, slave rd, expected rd, expected err
      vecs[0] = '{0, 1'b0, 32'h0000_0100, 32'h0,         4'hF, 2,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
      vecs[1] = '{1, 1'b1, 32'h0000_2000, 32'h1234_5678, 4'hF, 1,  32'hAAAA_5555, 32'h0,         1'b0};
      vecs[2] = '{1, 1'b0, 32'h0000_3004, 32'h0,         4'h3, 3,  32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
      vecs[3] = '{0, 1'b1, 32'h0000_0044, 32'h0BAD_C0DE, 4'h1, 5,  32'h7777_7777, 32'h0,         1'b0};
      vecs[4] = '{1, 1'b0, 32'h0000_5000, 32'h0,         4'hF, 0,  32'h0,         32'h0,         1'b1};
      vecs[5] = '{1, 1'b0, 32'h0000_6000, 32'h0,         4'hF, 16, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0};
      vecs[6] = '{0, 1'b0, 32'h0000_7000, 32'h0,         4'hF, 1,  32'h2468_ACE0, 32'h2468_ACE0, 1'b0};
      vecs[7] = '{0, 1'b0, 32'h0000_8000, 32'h0,         4'hF, 0,  32'h0,         32'h0,         1'b1};
      vecs[8] = '{1, 1'b1, 32'h0000_9000, 32'h55AA_55AA, 4'hC, 2,  32'h9999_9999, 32'h0,         1'b0};

      rst = 1'b1;
      m0_req_i = 0; m0_we_i = 0; m0_addr_i = 0; m0_wdata_i = 0; m0_sel_i = 0;
      m1_req_i = 0; m1_we_i = 0; m1_addr_i = 0; m1_wdata_i = 0; m1_sel_i = 0;
      s_ack_i = 0; s_rdata_i = 0;
      repeat (2) tick();
      chk("rst_sreq", {31'd0, s_req_o}, 32'd0);
      chk("rst_saddr", s_addr_o, 32'd0);
      chk("rst_acks", {28'd0, m1_err_o, m0_err_o, m1_ack_o, m0_ack_o}, 32'd0);
      chk("rst_rdata", m0_rdata_o | m1_rdata_o, 32'd0);
      chk("rst_stall", {30'd0, stallreq_mem_o, stallreq_if_o}, 32'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

      // Contention: last owner is m1 after the final table vector.
`ifdef ARB_RR_EN
      first_m = 0;
`else
      first_m = 1;
`endif
      second_m = 1 - first_m;
      drive(0, 1'b0, 32'h0000_0300, 32'h0, 4'hF);
      drive(1, 1'b1, 32'h0000_2000, 32'h1234_5678, 4'hF);
      sb_q.push_back('{first_m,  (first_m  == 0) ? 32'h1111_2222 : 32'h0, 1'b0});
      sb_q.push_back('{second_m, (second_m == 0) ? 32'h1111_2222 : 32'h0, 1'b0});
      tick();
      chk("cont_first_addr", s_addr_o, (first_m == 1) ? 32'h0000_2000 : 32'h0000_0300);
      s_ack_i = 1'b1; s_rdata_i = 32'h1111_2222;
      tick();
      s_ack_i = 1'b0;
      chk("cont_first_ack", {31'd0, ack_of(first_m)}, 32'd1);
      chk("cont_other_stall", {31'd0, stall_of(second_m)}, 32'd1);
      drop(first_m);
      tick();
      chk("cont_gap_sreq", {31'd0, s_req_o}, 32'd0);
      tick();
      chk("cont_second_sreq", {31'd0, s_req_o}, 32'd1);
      chk("cont_second_addr", s_addr_o, (second_m == 1) ? 32'h0000_2000 : 32'h0000_0300);
      if (second_m == 1) chk("cont_second_wdata", s_wdata_o, 32'h1234_5678);
      s_ack_i = 1'b1;
      tick();
      s_ack_i = 1'b0;
      chk("cont_second_ack", {31'd0, ack_of(second_m)}, 32'd1);
      drop(second_m);
      tick();

      // Held request: req stays high through RESP; reissued only from IDLE.
      drive(0, 1'b0, 32'h0000_0040, 32'h0, 4'hF);
      sb_q.push_back('{0, 32'hA5A5_A5A5, 1'b0});
      tick();
      s_ack_i = 1'b1; s_rdata_i = 32'hA5A5_A5A5;
      tick();
      s_ack_i = 1'b0;
      chk("held_ack", {31'd0, m0_ack_o}, 32'd1);
      tick();
      chk("held_no_dup", {31'd0, s_req_o}, 32'd0);
      sb_q.push_back('{0, 32'h5A5A_5A5A, 1'b0});
      tick();
      chk("held_reissue", {31'd0, s_req_o}, 32'd1);
      s_ack_i = 1'b1; s_rdata_i = 32'h5A5A_5A5A;
      tick();
      s_ack_i = 1'b0;
      chk("held_ack2", {31'd0, m0_ack_o}, 32'd1);
      drop(0);
      tick();

      // Reset during BUSY, then a late slave ack that must be ignored.
      drive(1, 1'b0, 32'h0000_B000, 32'h0, 4'hF);
      tick();
      chk("rstb_sreq", {31'd0, s_req_o}, 32'd1);
      tick();
      rst = 1'b1;
      #1;
      chk("rstb_sreq_off", {31'd0, s_req_o}, 32'd0);
      chk("rstb_saddr", s_addr_o, 32'd0);
      chk("rstb_rdata", m0_rdata_o | m1_rdata_o, 32'd0);
      drop(1);
      tick();
      rst = 1'b0;
      s_ack_i = 1'b1; s_rdata_i = 32'hFFFF_FFFF;
      tick();
      s_ack_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk("late_ack_ignored", {29'd0, s_req_o, m1_ack_o, m0_ack_o}, 32'd0);
         tick();
      end

      chk("sb_empty", sb_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the core's single external memory/peripheral bus between two requesters: instruction fetch (master 0) and the load/store access from the memory stage (master 1).
- Sits between the pipeline (pc_reg/if and mem stage) and the slave bus.
- Sequences one transaction at a time, returns read data and ack or error to the owning master, and raises per-master stall requests toward the pipeline controller.

Parameters:
- TMO_CYCLES, 16: maximum cycles spent in BUSY waiting for s_ack_i before the transaction is aborted. Legal range 1..255.

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- mN_req_i  input  1  (N=0,1) master N requests a transfer; held with command stable until mN_ack_o.
- mN_we_i  input  1  1 = write, 0 = read.
- mN_addr_i  input  32  byte address.
- mN_wdata_i  input  32  write data.
- mN_sel_i  input  4  byte lane enables.
- mN_rdata_o  output  32  read data, valid only while mN_ack_o=1.
- mN_ack_o  output  1  one-cycle completion pulse.
- mN_err_o  output  1  one-cycle timeout-abort pulse; coincides with mN_ack_o.
- s_req_o  output  1  slave request, registered.
- s_we_o  output  1  registered.
- s_addr_o  output  32  registered.
- s_wdata_o  output  32  registered.
- s_sel_o  output  4  registered.
- s_rdata_i  input  32  slave read data, valid with s_ack_i.
- s_ack_i  input  1  slave completion, 1 cycle.
- stallreq_if_o  output  1  = m0_req_i & ~m0_ack_o (combinational).
- stallreq_mem_o  output  1  = m1_req_i & ~m1_ack_o (combinational).

Behaviour:
- States: IDLE, BUSY, RESP. Registers: state, owner (1 bit), last_owner (1 bit), tmo counter (8 bit), rdata/ack/err registers.
- Reset (async, any state):
  - state=IDLE, owner=0, last_owner=0, counter=0.
  - s_req_o=0; s_we_o, s_addr_o, s_wdata_o, s_sel_o all 0.
  - mN_ack_o=0, mN_err_o=0, mN_rdata_o=0.
  - Any in-flight transaction is dropped; a late s_ack_i is ignored.
- IDLE:
  - No request: stay.
  - Any request: select owner per the arbitration rule, latch that master's we/addr/wdata/sel into the s_* registers, set s_req_o=1, counter=0, go to BUSY.
- BUSY:
  - s_req_o held 1; s_* registers held stable.
  - s_ack_i=1: capture s_rdata_i (write: capture 0) into mOwner_rdata_o, pulse mOwner_ack_o next cycle, s_req_o=0, go to RESP.
  - Else if counter==TMO_CYCLES-1: s_req_o=0, pulse mOwner_ack_o and mOwner_err_o, rdata=0, go to RESP.
  - Else counter+1.
  - s_ack_i and timeout in the same cycle: ack wins, no error.
- RESP (exactly 1 cycle):
  - ack/err pulse is visible; all requests ignored, so the finishing master's req still being high this cycle is not re-arbitrated.
  - last_owner=owner; go to IDLE.
- Latency:
  - Request first seen in IDLE on edge E0. s_req_o is high from E0.
  - With slave ack sampled at edge E0+k (k≥1), mN_ack_o is high during cycle E0+k..E0+k+1.
  - Minimum 3 cycles per transaction; back-to-back throughput is one transfer per (k+2) cycles.
- Ack of a non-owner master never asserts. Both acks are never high in the same cycle.
- s_ack_i while in IDLE or RESP: ignored.
- Default arbitration (fixed priority): m1 (data) wins when both request in IDLE.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin. When both request in IDLE, grant the master != last_owner. A single requester is always granted immediately.
- Undefined: fixed priority, m1 over m0. last_owner is still updated but unused.

Test Plan:
- Single read: m0_req_i=1, addr=0x00000100; slave acks 2 cycles after s_req_o with rdata 0xDEADBEEF -> s_addr_o=0x100, s_we_o=0; m0_ack_o one cycle with m0_rdata_o=0xDEADBEEF; stallreq_if_o high until that cycle.
- Contention: m0 and m1 both request on the same edge, m1 write addr 0x2000 wdata 0x12345678 sel 0xF -> m1 served first. Without ARB_RR_EN, m0 waits; m0 is granted in the IDLE after RESP. With ARB_RR_EN and last_owner=1, m0 is granted first instead.
- Timeout: m1 read, s_ack_i never asserted, TMO_CYCLES=16 -> s_req_o drops after exactly 16 BUSY cycles; m1_ack_o=m1_err_o=1 for one cycle; m1_rdata_o=0.
- Ack/timeout race: s_ack_i asserted in the 16th BUSY cycle -> normal ack with data, m1_err_o=0.
- Held request: master keeps req=1 through RESP -> no duplicate s_req_o during RESP; re-issued only from IDLE.
- Reset mid-BUSY: assert rst while s_req_o=1, then s_ack_i arrives after release -> all outputs 0 immediately on rst; the late ack produces no mN_ack_o.
